// File: rtl/clks_alot_p.sv
// Shared types and constants for the clock-rate monitoring blocks.
// Limit sets are expressed in half-period counts of the system clock.
package clks_alot_p;

  localparam int RATE_COUNTER_WIDTH = 8;

  typedef logic [RATE_COUNTER_WIDTH-1:0] rate_t;

  typedef struct packed {
    rate_t min_band;
    rate_t min_viol;
    rate_t max_viol;
    rate_t max_band;
  } half_rate_limits_s;

  localparam half_rate_limits_s DEFAULT_HALF_RATE_LIMITS = '{
    min_band: 8'd1,
    min_viol: 8'd2,
    max_viol: 8'd200,
    max_band: 8'd250
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

  function automatic rate_t sat_inc(input rate_t value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/rate_counter_sat.sv
// Saturating up-counter with synchronous clear and hold; flags when pinned
// at all-ones so callers can treat saturation as a timeout.
module rate_counter_sat #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             hold_i,
  output logic [WIDTH-1:0] count_o,
  output logic             sat_o
);

  assign sat_o = (count_o == '1);

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (clr_i) begin
      count_o <= '0;
    end else if (!hold_i && !sat_o) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/rate_lock_controller.sv
// Lock sequencer for one monitored clock: drives the rate counter and limit
// set into the event filter, and tracks lock from the filter's verdicts.
module rate_lock_controller
  import clks_alot_p::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  half_rate_limits_s             cfg_limits_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic                          event_i,
  input  logic                          ignore_filtered_event_i,
  input  logic                          over_frequency_violation_i,
  input  logic                          under_frequency_violation_i,
  output logic [RATE_COUNTER_WIDTH-1:0] rate_counter_o,
  output half_rate_limits_s             active_limits_o,
  output logic                          locked_o,
  output logic                          lost_o,
  output logic [RATE_COUNTER_WIDTH-1:0] measured_half_rate_o,
  output logic                          measured_valid_o
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int VIOL_W = $clog2(UNLOCK_COUNT + 1);

  lock_state_e       state;
  logic [GOOD_W-1:0] good_cnt;
  logic [VIOL_W-1:0] viol_cnt;
  logic              good;
  logic              bad;
  logic              timeout;
  logic              cfg_accept;
  logic              in_idle;

  assign in_idle    = (state == IDLE);
  assign good       = ignore_filtered_event_i & ~over_frequency_violation_i
                      & ~under_frequency_violation_i;
  assign bad        = event_i & (over_frequency_violation_i | under_frequency_violation_i);
  // An accepted event is the only point where the filter is between comparisons.
  assign cfg_ready_o = in_idle | ignore_filtered_event_i;
  assign cfg_accept  = cfg_valid_i & cfg_ready_o;
  assign locked_o    = (state == LOCKED);

  rate_counter_sat #(
    .WIDTH(RATE_COUNTER_WIDTH)
  ) u_rate_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (in_idle | ~enable_i | ignore_filtered_event_i),
    .hold_i (1'b0),
    .count_o(rate_counter_o),
    .sat_o  (timeout)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      good_cnt <= '0;
      viol_cnt <= '0;
      lost_o   <= 1'b0;
    end else begin
      lost_o <= 1'b0;
      if (!enable_i) begin
        state    <= IDLE;
        good_cnt <= '0;
        viol_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state    <= ACQUIRE;
            good_cnt <= '0;
            viol_cnt <= '0;
          end
          ACQUIRE, LOCKED: begin
            if (cfg_accept) begin
              // New limits invalidate the current lock without reporting a loss.
              state    <= ACQUIRE;
              good_cnt <= '0;
              viol_cnt <= '0;
            end else if (state == ACQUIRE) begin
              if (bad) begin
                good_cnt <= '0;
              end else if (good) begin
                if (good_cnt == GOOD_W'(LOCK_COUNT - 1)) begin
                  state    <= LOCKED;
                  good_cnt <= '0;
                  viol_cnt <= '0;
                end else begin
                  good_cnt <= good_cnt + 1'b1;
                end
              end else if (timeout) begin
                good_cnt <= '0;
              end
            end else begin
              if (timeout || (bad && viol_cnt == VIOL_W'(UNLOCK_COUNT - 1))) begin
                state    <= ACQUIRE;
                good_cnt <= '0;
                viol_cnt <= '0;
                lost_o   <= 1'b1;
              end else if (bad) begin
                viol_cnt <= viol_cnt + 1'b1;
              end else if (good && viol_cnt != '0) begin
                viol_cnt <= viol_cnt - 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_limits_o <= DEFAULT_HALF_RATE_LIMITS;
    end else if (cfg_accept) begin
      active_limits_o <= cfg_limits_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      measured_half_rate_o <= '0;
      measured_valid_o     <= 1'b0;
    end else begin
      measured_valid_o <= 1'b0;
      if (ignore_filtered_event_i && !in_idle) begin
        measured_half_rate_o <= sat_inc(rate_counter_o);
        measured_valid_o     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rate_lock_controller.sv
// Directed bench for rate_lock_controller; the filter verdicts are driven by
// hand so every expected value follows from the chosen event spacing.
module tb_rate_lock_controller;
  import clks_alot_p::*;

  localparam logic [31:0] EXP_DEFAULT = 32'h0102_C8FA;
  localparam logic [31:0] LIM_A       = 32'h0204_0C0F;
  localparam logic [31:0] LIM_B       = 32'h0305_141E;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  half_rate_limits_s cfg_limits;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ev;
  logic              ign;
  logic              ov;
  logic              un;
  logic [7:0]        rate;
  half_rate_limits_s active_limits;
  logic              locked;
  logic              lost;
  logic [7:0]        measured;
  logic              mvalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rate_lock_controller #(
    .LOCK_COUNT  (4),
    .UNLOCK_COUNT(3)
  ) dut (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .enable_i                   (enable),
    .cfg_limits_i               (cfg_limits),
    .cfg_valid_i                (cfg_valid),
    .cfg_ready_o                (cfg_ready),
    .event_i                    (ev),
    .ignore_filtered_event_i    (ign),
    .over_frequency_violation_i (ov),
    .under_frequency_violation_i(un),
    .rate_counter_o             (rate),
    .active_limits_o            (active_limits),
    .locked_o                   (locked),
    .lost_o                     (lost),
    .measured_half_rate_o       (measured),
    .measured_valid_o           (mvalid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ev(input logic e, input logic i, input logic o, input logic u);
    ev  = e;
    ign = i;
    ov  = o;
    un  = u;
  endtask

  task automatic idle(input int n);
    set_ev(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (n) step();
  endtask

  task automatic good_ev(input logic [7:0] exp_meas);
    set_ev(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    set_ev(1'b0, 1'b0, 1'b0, 1'b0);
    check("meas", measured, exp_meas);
    check("mvalid", mvalid, 1);
    check("rate_clr", rate, 0);
  endtask

  // Good events spaced 8 cycles apart, starting with the rate counter at 0.
  task automatic run_good(input int n, input int lock_at);
    for (int i = 0; i < n; i++) begin
      idle(7);
      check("rate7", rate, 7);
      check("mvalid_low", mvalid, 0);
      good_ev(8);
      check("locked_seq", locked, (i + 1 >= lock_at) ? 1 : 0);
      check("lost_seq", lost, 0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    cfg_valid  = 1'b0;
    cfg_limits = '0;
    set_ev(1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check("rst_rate", rate, 0);
    check("rst_limits", active_limits, EXP_DEFAULT);
    check("rst_locked", locked, 0);
    check("rst_lost", lost, 0);
    check("rst_mvalid", mvalid, 0);
    check("rst_meas", measured, 0);
    check("rst_ready", cfg_ready, 1);
    step();
    rst = 1'b0;

    // Load limits while idle.
    cfg_limits = LIM_A;
    cfg_valid  = 1'b1;
    #1;
    check("idle_ready", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    check("limits_a", active_limits, LIM_A);
    check("idle_rate", rate, 0);

    // Acquire and lock on 8-cycle spacing.
    enable = 1'b1;
    step();
    check("acq_rate0", rate, 0);
    check("acq_unlocked", locked, 0);
    run_good(4, 4);

    // Three over-frequency violations unlock on the third.
    for (int k = 0; k < 3; k++) begin
      idle(13);
      set_ev(1'b1, 1'b0, 1'b1, 1'b0);
      step();
      set_ev(1'b0, 1'b0, 1'b0, 1'b0);
      check("viol_mvalid", mvalid, 0);
      check("viol_rate", rate, 14 * (k + 1));
      check("viol_locked", locked, (k < 2) ? 1 : 0);
      check("viol_lost", lost, (k == 2) ? 1 : 0);
    end
    step();
    check("lost_one_cycle", lost, 0);
    check("acq_after_loss", locked, 0);
    good_ev(44);
    check("resync_unlocked", locked, 0);
    run_good(3, 3);

    // Alternating violation/good never reaches the unlock score.
    for (int k = 0; k < 4; k++) begin
      idle(7);
      set_ev(1'b1, 1'b0, 1'b1, 1'b0);
      step();
      check("alt_bad_locked", locked, 1);
      check("alt_bad_lost", lost, 0);
      good_ev(9);
      check("alt_good_locked", locked, 1);
    end

    // Glitches inside the ignore band are not measured and do not clear the counter.
    idle(3);
    set_ev(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    set_ev(1'b0, 1'b0, 1'b0, 1'b0);
    check("glitch_mvalid", mvalid, 0);
    check("glitch_rate", rate, 5);
    check("glitch_locked", locked, 1);
    good_ev(6);
    check("glitch_relock", locked, 1);

    // Limit set offered while locked waits for an accepted event.
    cfg_limits = LIM_B;
    cfg_valid  = 1'b1;
    idle(3);
    check("cfg_ready_low", cfg_ready, 0);
    check("cfg_not_applied", active_limits, LIM_A);
    idle(4);
    set_ev(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check("cfg_ready_event", cfg_ready, 1);
    step();
    set_ev(1'b0, 1'b0, 1'b0, 1'b0);
    cfg_valid = 1'b0;
    check("limits_b", active_limits, LIM_B);
    check("cfg_meas", measured, 8);
    check("cfg_mvalid", mvalid, 1);
    check("cfg_unlocked", locked, 0);
    check("cfg_no_lost", lost, 0);
    run_good(4, 4);

    // Events stop: counter saturates and the lock times out.
    idle(254);
    check("pre_sat_rate", rate, 254);
    check("pre_sat_locked", locked, 1);
    step();
    check("sat_rate", rate, 255);
    check("sat_locked", locked, 1);
    check("sat_lost_pre", lost, 0);
    step();
    check("sat_hold", rate, 255);
    check("timeout_unlocked", locked, 0);
    check("timeout_lost", lost, 1);
    step();
    check("timeout_lost_end", lost, 0);
    good_ev(255);
    check("sat_meas_unlocked", locked, 0);

    // Asynchronous reset in the middle of acquisition.
    idle(3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rate", rate, 0);
    check("arst_limits", active_limits, EXP_DEFAULT);
    check("arst_locked", locked, 0);
    check("arst_lost", lost, 0);
    check("arst_mvalid", mvalid, 0);
    check("arst_meas", measured, 0);
    check("arst_ready", cfg_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst_rate", rate, 0);
    check("post_rst_ready", cfg_ready, 0);
    step();
    check("post_rst_count", rate, 1);

    // Dropping enable returns to idle and holds the counter.
    enable = 1'b0;
    step();
    check("dis_rate", rate, 0);
    check("dis_ready", cfg_ready, 1);
    step();
    check("dis_hold", rate, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
